// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side character buffer placed directly after the UART receiver.
//   Each completed character ({parity error, 8-bit data}) is captured on the
//   rising edge of rx_done and stored in a circular FIFO of 2^DEPTH_LOG2
//   entries. The host pops characters and sees level, overflow and
//   interrupt status.
//
//   Optional feature macro: UART_RX_TIMEOUT_EN
//     defined   : character-timeout counter drives timeout_irq
//     undefined : timeout_irq is tied to 0
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_done            receiver frame-finished level (edge detected here)
//   rx_data, pari_err  received byte and its parity-error flag
//   rd_en              host pop request
//   flush              synchronous FIFO clear
//   ovf_clr            clears the sticky overflow flag
//   irq_en, thresh     level interrupt enable and threshold
//   rd_data, rd_perr   popped character (held until the next pop)
//   rd_valid           one-cycle pulse when rd_data/rd_perr update
//   empty, full, count occupancy status (registered)
//   overflow           sticky: a character was dropped
//   rx_irq             level interrupt
//   timeout_irq        character-timeout flag
module uart_rx_fifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  input  logic                  pari_err,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  ovf_clr,
  input  logic                  irq_en,
  input  logic [DEPTH_LOG2:0]   thresh,
  output logic [7:0]            rd_data,
  output logic                  rd_perr,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  rx_irq,
  output logic                  timeout_irq
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  // Elaboration-time sanity check on the configuration.
  if (DEPTH_LOG2 < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_rx_fifo: DEPTH_LOG2 must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  logic [8:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  rx_done_d;

  logic                  wr_req;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  is_full;
  logic                  ovf_set;
  logic [DEPTH_LOG2:0]   count_next;
  logic [DEPTH_LOG2:0]   thresh_eff;

  // One write per rx_done assertion, however long the level lasts.
  assign wr_req  = rx_done & ~rx_done_d;
  assign is_full = (count == DEPTH_CNT);

  // count is checked before update, so a read on an empty FIFO is ignored
  // even if a write lands in the same cycle. flush cancels both.
  assign rd_ok   = rd_en & (count != '0) & ~flush;
  // When full, a same-cycle pop frees the slot the write needs.
  assign wr_ok   = wr_req & ~flush & (~is_full | rd_ok);
  assign ovf_set = wr_req & ~flush & is_full & ~rd_ok;

  // thresh=0 behaves as 1; thresholds above depth can never be reached.
  assign thresh_eff = (thresh == '0) ? (DEPTH_LOG2+1)'(1) : thresh;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  // Storage array: no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {pari_err, rx_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_done_d <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      rd_data   <= '0;
      rd_perr   <= 1'b0;
      rd_valid  <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      rx_done_d <= rx_done;
      rd_valid  <= rd_ok;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      end

      if (rd_ok) begin
        {rd_perr, rd_data} <= mem[rd_ptr];
      end

      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_CNT);

      // A new drop outranks a same-cycle clear.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      rx_irq <= irq_en & (count_next >= thresh_eff);
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int           TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_clr;

  // Any FIFO activity, or nothing to wait for, restarts the idle count.
  assign tmo_clr = wr_ok | rd_ok | flush | (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_irq <= 1'b0;
    end else begin
      if (tmo_clr)                tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;

      // Sticky until the host pops or flushes; a write alone does not clear it.
      if (rd_ok | flush)                          timeout_irq <= 1'b0;
      else if (!tmo_clr && tmo_cnt == TMO_LAST)   timeout_irq <= 1'b1;
    end
  end
`else
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          pari_err = 1'b0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          irq_en = 1'b0;
  logic [DL:0]   thresh = '0;
  logic [7:0]    rd_data;
  logic          rd_perr;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [DL:0]   count;
  logic          overflow;
  logic          rx_irq;
  logic          timeout_irq;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [8:0] exp_q [$];

  uart_rx_fifo #(.DEPTH_LOG2(DL), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .pari_err(pari_err), .rd_en(rd_en), .flush(flush), .ovf_clr(ovf_clr),
    .irq_en(irq_en), .thresh(thresh), .rd_data(rd_data), .rd_perr(rd_perr),
    .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .rx_irq(rx_irq), .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s = 0x%0h", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected character.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got perr=%0b data=0x%02h, expected no rd_valid", rd_perr, rd_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({rd_perr, rd_data} === e) begin
          pass_cnt++;
          $display("ok   pop perr=%0b data=0x%02h", rd_perr, rd_data);
        end else begin
          $display("FAIL pop_data: got perr=%0b data=0x%02h, expected perr=%0b data=0x%02h",
                   rd_perr, rd_data, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] d, input logic p);
    @(posedge clk); #1;
    rx_done = 1'b1; rx_data = d; pari_err = p;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic pop(input logic [8:0] e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic pulse_ovf_clr();
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rx_irq", rx_irq, 0);
    check("rst_timeout_irq", timeout_irq, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fill to depth
    write_byte(8'h11, 0); write_byte(8'h22, 0);
    write_byte(8'h33, 0); write_byte(8'h44, 0);
    @(negedge clk);
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    check("fill_empty", empty, 0);

    // Write while full: dropped, overflow set
    write_byte(8'h55, 0);
    @(negedge clk);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 4);
    pulse_ovf_clr();
    @(negedge clk);
    check("ovf_clr", overflow, 0);

    // Simultaneous write and read while full: both happen, no overflow
    exp_q.push_back({1'b0, 8'h11});
    @(posedge clk); #1;
    rx_done = 1'b1; rx_data = 8'h66; rd_en = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("wr_rd_full_count", count, 4);
    check("wr_rd_full_ovf", overflow, 0);

    // Drain; 0x55 was dropped, 0x66 went in behind 0x44
    pop({1'b0, 8'h22}); pop({1'b0, 8'h33});
    pop({1'b0, 8'h44}); pop({1'b0, 8'h66});
    @(negedge clk);
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);

    // Long rx_done level: exactly one write, parity flag captured
    @(posedge clk); #1;
    rx_done = 1'b1; rx_data = 8'hA5; pari_err = 1'b1;
    repeat (5) @(posedge clk);
    #1 rx_done = 1'b0; pari_err = 1'b0;
    @(negedge clk);
    check("edge_count", count, 1);
    pop({1'b1, 8'hA5});

    // Simultaneous write and read while empty: write only
    @(posedge clk); #1;
    rx_done = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("wr_rd_empty_count", count, 1);
    check("wr_rd_empty_valid", rd_valid, 0);
    pop({1'b0, 8'h77});

    // Flush with same-cycle write and read, overflow previously set
    write_byte(8'h01, 0); write_byte(8'h02, 0);
    write_byte(8'h03, 0); write_byte(8'h04, 0);
    write_byte(8'h05, 0);
    @(posedge clk); #1;
    flush = 1'b1; rx_done = 1'b1; rx_data = 8'h99; rd_en = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; rx_done = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_ovf_kept", overflow, 1);
    check("flush_rd_data_kept", rd_data, 8'h77);
    pulse_ovf_clr();

    // Level interrupt
    irq_en = 1'b1; thresh = 3;
    write_byte(8'hA1, 0); write_byte(8'hA2, 0);
    @(negedge clk);
    check("irq_below", rx_irq, 0);
    write_byte(8'hA3, 0);
    @(negedge clk);
    check("irq_at", rx_irq, 1);
    pop({1'b0, 8'hA1});
    @(negedge clk);
    check("irq_after_pop", rx_irq, 0);
    do_flush();
    thresh = 0;
    write_byte(8'hB1, 0);
    @(negedge clk);
    check("irq_thresh0", rx_irq, 1);
    thresh = 5;
    write_byte(8'hB2, 0); write_byte(8'hB3, 0); write_byte(8'hB4, 0);
    @(negedge clk);
    check("irq_thresh_gt_depth", rx_irq, 0);
    thresh = 4;
    @(negedge clk);
    check("irq_thresh_depth", rx_irq, 1);
    irq_en = 1'b0;
    do_flush();

    // Character timeout
    write_byte(8'hC1, 0);
`ifdef UART_RX_TIMEOUT_EN
    n = 0;
    while (!timeout_irq && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_fired", timeout_irq, 1);
    check("tmo_not_early", 32'(n >= 13), 1);
    pop({1'b0, 8'hC1});
    @(negedge clk);
    check("tmo_cleared", timeout_irq, 0);
`else
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | timeout_irq;
    end
    check("tmo_disabled", seen, 0);
    pop({1'b0, 8'hC1});
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
